// File: rtl/cpm_cnt_nest_if.sv
// ---------------------------------------------------------------------------
// cpm_cnt_nest_if
//   Control/status bundle for the nested-loop counter of the compute-path
//   manager. The master side (sequencer or bench) drives clear/start/enable
//   and the per-level terminal values. The slave side (the counter) returns
//   the packed counts, the per-level wrap flags and the run status.
//
//   Signals (level 0 innermost, at the LSB of every packed bus):
//     clear    M->S  synchronous clear of counts and FSM
//     start    M->S  begin a run (accepted only while idle)
//     enable   M->S  advance one step (effective only while running)
//     cfg_max  M->S  NUM_LVL*DW per-level terminal values, latched at start
//     cnt      S->M  NUM_LVL*DW current per-level counts
//     wrap     S->M  NUM_LVL combinational per-level wrap of this step
//     busy     S->M  high while running
//     done     S->M  one-cycle pulse after the final step
//     lin_cnt  S->M  linear step count (only with CPM_CNT_NEST_LINCNT_EN)
//
//   Optional feature macro: CPM_CNT_NEST_LINCNT_EN
// ---------------------------------------------------------------------------
interface cpm_cnt_nest_if #(
  parameter int DW      = 8,
  parameter int NUM_LVL = 3
);
  logic                    clear;
  logic                    start;
  logic                    enable;
  logic [NUM_LVL*DW-1:0]   cfg_max;
  logic [NUM_LVL*DW-1:0]   cnt;
  logic [NUM_LVL-1:0]      wrap;
  logic                    busy;
  logic                    done;
`ifdef CPM_CNT_NEST_LINCNT_EN
  logic [NUM_LVL*DW-1:0]   lin_cnt;
`endif

  modport master (
    output clear,
    output start,
    output enable,
    output cfg_max,
`ifdef CPM_CNT_NEST_LINCNT_EN
    input  lin_cnt,
`endif
    input  cnt,
    input  wrap,
    input  busy,
    input  done
  );

  modport slave (
    input  clear,
    input  start,
    input  enable,
    input  cfg_max,
`ifdef CPM_CNT_NEST_LINCNT_EN
    output lin_cnt,
`endif
    output cnt,
    output wrap,
    output busy,
    output done
  );
endinterface

// File: rtl/cpm_cnt_nest.sv
// ---------------------------------------------------------------------------
// cpm_cnt_nest
//   Parametrised nested-loop counter for the compute-path manager. NUM_LVL
//   chained DW-bit counters step through the full index space
//   (tile / channel / point) one Enable at a time. Each level counts
//   0..Max_i and hands a carry to the next outer level when it wraps. The run
//   ends when the outermost level wraps, which returns every count to 0 and
//   produces a one-cycle Done pulse.
//
//   Ports:
//     i_clk   clock, all state changes on the rising edge
//     i_rst   asynchronous active-high reset
//     bus     cpm_cnt_nest_if.slave (clear/start/enable/cfg_max in,
//             cnt/wrap/busy/done[/lin_cnt] out)
//
//   Priority of controls: reset > clear > start > enable.
//
//   Optional feature macro: CPM_CNT_NEST_LINCNT_EN
//     When defined, bus.lin_cnt counts effective steps of the current run.
//     It clears on reset, clear and an accepted start, and holds its final
//     value through DONE and IDLE.
// ---------------------------------------------------------------------------
module cpm_cnt_nest #(
  parameter int DW      = 8,
  parameter int NUM_LVL = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cpm_cnt_nest_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_busy;
  logic                r_done;

  logic                w_start_acc;  // start accepted this cycle
  logic                w_step;       // effective enable this cycle
  logic [NUM_LVL-1:0]  w_carry;      // carry into each level
  logic [NUM_LVL-1:0]  w_wrap;       // level wraps on this step
  logic                w_last_step;  // outermost level wraps: final step

  // Clear outranks both start and enable, so neither is effective in a
  // cycle where clear is high.
  assign w_start_acc = (r_state == ST_IDLE) && bus.start  && !bus.clear;
  assign w_step      = (r_state == ST_RUN)  && bus.enable && !bus.clear;
  assign w_last_step = w_wrap[NUM_LVL-1];

  // -------------------------------------------------------------------------
  // Per-level counter slices
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LVL; gi++) begin : g_lvl
      logic [DW-1:0] r_cnt_lvl;
      logic [DW-1:0] r_max_lvl;
      logic [DW-1:0] w_cnt_next;
      logic          w_at_max;

      // Level 0 is fed by the step itself; each outer level only sees a
      // carry when every inner level wrapped on the same step.
      if (gi == 0) begin : g_carry_in0
        assign w_carry[gi] = w_step;
      end else begin : g_carry_inn
        assign w_carry[gi] = w_wrap[gi-1];
      end

      assign w_at_max    = (r_cnt_lvl == r_max_lvl);
      // Max=0 means the level is always at its terminal value, so the carry
      // passes straight through to the next level.
      assign w_wrap[gi]  = w_carry[gi] && w_at_max;

      always_comb begin
        w_cnt_next = r_cnt_lvl;
        if (bus.clear || w_start_acc) begin
          w_cnt_next = '0;
        end else if (w_carry[gi]) begin
          // Increment never passes the terminal value, so no DW overflow,
          // and an all-ones terminal value simply wraps to 0 here.
          w_cnt_next = w_wrap[gi] ? '0 : r_cnt_lvl + 1'b1;
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cnt_lvl <= '0;
        end else begin
          r_cnt_lvl <= w_cnt_next;
        end
      end

      // Terminal values are latched only on an accepted start, so cfg_max
      // may change freely during a run. Clear keeps them.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_max_lvl <= '0;
        end else if (w_start_acc) begin
          r_max_lvl <= bus.cfg_max[gi*DW +: DW];
        end
      end

      assign bus.cnt[gi*DW +: DW] = r_cnt_lvl;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Run-control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last_step) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Start and enable are ignored here; always back to idle.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (bus.clear) begin
      w_state_next = ST_IDLE;
    end
  end

  // Busy/Done are registered from the next state so they line up exactly
  // with the RUN and DONE state cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  assign bus.wrap = w_wrap;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // -------------------------------------------------------------------------
  // Optional linear step counter
  // -------------------------------------------------------------------------
`ifdef CPM_CNT_NEST_LINCNT_EN
  logic [NUM_LVL*DW-1:0] r_lin_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lin_cnt <= '0;
    end else if (bus.clear || w_start_acc) begin
      r_lin_cnt <= '0;
    end else if (w_step) begin
      r_lin_cnt <= r_lin_cnt + 1'b1;
    end
  end

  assign bus.lin_cnt = r_lin_cnt;
`endif

endmodule

// File: tb/tb_cpm_cnt_nest.sv
// ---------------------------------------------------------------------------
// tb_cpm_cnt_nest
//   Self-checking bench for cpm_cnt_nest with DW=4, NUM_LVL=3. Expected
//   counts and wrap flags come from a mixed-radix view of the run: after k
//   effective steps, level i holds (k / prod_{j<i}(Max_j+1)) mod (Max_i+1),
//   and step n wraps level i when n is a multiple of prod_{j<=i}(Max_j+1).
// ---------------------------------------------------------------------------
module tb_cpm_cnt_nest;
  localparam int DW = 4;
  localparam int NL = 3;
  localparam int W  = NL * DW;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cpm_cnt_nest_if #(.DW(DW), .NUM_LVL(NL)) bus ();

  cpm_cnt_nest #(.DW(DW), .NUM_LVL(NL)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic int lvl_max(input logic [W-1:0] cfg, input int i);
    return int'(cfg[i*DW +: DW]);
  endfunction

  // Product of (Max_j+1) for j < n.
  function automatic int radix(input logic [W-1:0] cfg, input int n);
    int p;
    p = 1;
    for (int j = 0; j < n; j++) p = p * (lvl_max(cfg, j) + 1);
    return p;
  endfunction

  function automatic logic [W-1:0] exp_cnt(input logic [W-1:0] cfg, input int k);
    logic [W-1:0] e;
    int           v;
    e = '0;
    for (int i = 0; i < NL; i++) begin
      v = (k / radix(cfg, i)) % (lvl_max(cfg, i) + 1);
      e[i*DW +: DW] = v[DW-1:0];
    end
    return e;
  endfunction

  function automatic logic [NL-1:0] exp_wrap(input logic [W-1:0] cfg, input int n);
    logic [NL-1:0] w;
    for (int i = 0; i < NL; i++) w[i] = ((n % radix(cfg, i + 1)) == 0);
    return w;
  endfunction

  // ------------------------------------------------------------ run engine
  // Start a run with cfg, step it with the given enable pattern
  // (0: held high, 1: 1,0,0,1 repeating, 2: random), optionally poke start
  // with a different cfg mid-run, optionally clear after clear_at steps.
  task automatic run_seq(input string name, input logic [W-1:0] cfg,
                         input int mode, input int clear_at, input bit poke);
    int            total;
    int            k;
    int            cyc;
    logic          en;
    logic [NL-1:0] ew;
    total = radix(cfg, NL);
    bus.cfg_max = cfg;
    bus.start   = 1'b1;
    bus.enable  = 1'b0;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.cfg_max = W'($urandom);
    checks++;
    if (bus.busy !== 1'b1 || bus.cnt !== '0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b cnt=%h done=%b want busy=1 cnt=0 done=0",
               name, bus.busy, bus.cnt, bus.done);
    end
    k   = 0;
    cyc = 0;
    while (k < total) begin
      if (cyc >= 4000) begin
        errors++;
        checks++;
        $display("FAIL %s timeout: steps=%0d want %0d", name, k, total);
        return;
      end
      case (mode)
        0:       en = 1'b1;
        1:       en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: en = 1'($urandom_range(0, 1));
      endcase
      bus.enable = en;
      if (poke && k == 2) begin
        bus.start   = 1'b1;
        bus.cfg_max = ~cfg;
      end
      if (k == clear_at) begin
        en         = 1'b0;
        bus.enable = 1'b0;
        bus.clear  = 1'b1;
      end
      #1;
      ew = en ? exp_wrap(cfg, k + 1) : '0;
      checks++;
      if (bus.wrap !== ew) begin
        errors++;
        $display("FAIL %s wrap step %0d: got %b want %b", name, k + 1, bus.wrap, ew);
      end
      @(posedge clk); #1;
      bus.clear = 1'b0;
      bus.start = 1'b0;
      if (k == clear_at) begin
        checks++;
        if (bus.cnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL %s clear: cnt=%h busy=%b done=%b want 0 0 0",
                   name, bus.cnt, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s post_clear: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
        end
`ifdef CPM_CNT_NEST_LINCNT_EN
        checks++;
        if (bus.lin_cnt !== '0) begin
          errors++;
          $display("FAIL %s lincnt_clear: got %0d want 0", name, bus.lin_cnt);
        end
`endif
        $display("run %s cfg=%h cleared after %0d steps", name, cfg, k);
        return;
      end
      if (en) k++;
      cyc++;
      if (k == total) begin
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cnt !== '0) begin
          errors++;
          $display("FAIL %s done: done=%b busy=%b cnt=%h want 1 0 0",
                   name, bus.done, bus.busy, bus.cnt);
        end
      end else begin
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.cnt !== exp_cnt(cfg, k)) begin
          errors++;
          $display("FAIL %s step %0d: done=%b busy=%b cnt=%h want 0 1 %h",
                   name, k, bus.done, bus.busy, bus.cnt, exp_cnt(cfg, k));
        end
      end
`ifdef CPM_CNT_NEST_LINCNT_EN
      checks++;
      if (bus.lin_cnt !== W'(k)) begin
        errors++;
        $display("FAIL %s lincnt: got %0d want %0d", name, bus.lin_cnt, k);
      end
`endif
    end
    // DONE cycle: start and enable must be ignored, Done must not repeat.
    bus.start   = poke;
    bus.enable  = 1'b1;
    bus.cfg_max = cfg;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.enable = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cnt !== '0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b cnt=%h want 0 0 0",
               name, bus.done, bus.busy, bus.cnt);
    end
`ifdef CPM_CNT_NEST_LINCNT_EN
    checks++;
    if (bus.lin_cnt !== W'(total)) begin
      errors++;
      $display("FAIL %s lincnt_hold: got %0d want %0d", name, bus.lin_cnt, total);
    end
`endif
    $display("run %s cfg=%h steps=%0d cycles=%0d", name, cfg, total, cyc);
  endtask

  // -------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.cnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap !== '0) begin
      errors++;
      $display("FAIL reset_state: cnt=%h busy=%b done=%b wrap=%b want all 0",
               bus.cnt, bus.busy, bus.done, bus.wrap);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enable = 1'b1;
      #1;
      checks++;
      if (bus.wrap !== '0) begin
        errors++;
        $display("FAIL idle_wrap: got %b want 000", bus.wrap);
      end
      @(posedge clk); #1;
      bus.enable = 1'b0;
      checks++;
      if (bus.cnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL idle_enable: cnt=%h busy=%b done=%b want 0 0 0",
                 bus.cnt, bus.busy, bus.done);
      end
    end
    $display("reset and idle enable pulses checked");
    // Asynchronous reset in the middle of a run.
    bus.cfg_max = 12'h213;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt=%h busy=%b done=%b want 0 0 0",
               bus.cnt, bus.busy, bus.done);
    end
    bus.enable = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
    end
`ifdef CPM_CNT_NEST_LINCNT_EN
    checks++;
    if (bus.lin_cnt !== '0) begin
      errors++;
      $display("FAIL reset_lincnt: got %0d want 0", bus.lin_cnt);
    end
`endif
    $display("mid-run async reset checked");
  endtask

  task automatic test_full_run();
    run_seq("full_nest", 12'h213, 0, -1, 1'b0);
  endtask

  task automatic test_stalls();
    run_seq("stall_1001", 12'h213, 1, -1, 1'b0);
    run_seq("stall_rand", 12'h213, 2, -1, 1'b0);
  endtask

  task automatic test_degenerate();
    run_seq("all_zero", 12'h000, 0, -1, 1'b0);
    run_seq("l1_zero", 12'h102, 0, -1, 1'b0);
    run_seq("l0_full", 12'h10F, 2, -1, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_seq("start_poke", 12'h213, 1, -1, 1'b1);
  endtask

  task automatic test_clear_mid_run();
    run_seq("clear_at10", 12'h213, 0, 10, 1'b0);
    run_seq("after_clear", 12'h213, 0, -1, 1'b0);
  endtask

  task automatic test_random_cfg();
    logic [W-1:0] cfg;
    for (int r = 0; r < 5; r++) begin
      cfg = '0;
      for (int i = 0; i < NL; i++) cfg[i*DW +: DW] = DW'($urandom_range(0, 3));
      run_seq("random_cfg", cfg, 2, -1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.clear   = 1'b0;
    bus.start   = 1'b0;
    bus.enable  = 1'b0;
    bus.cfg_max = '0;
    test_reset();
    test_full_run();
    test_stalls();
    test_degenerate();
    test_ignored_start();
    test_clear_mid_run();
    test_random_cfg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpm_cnt_nest.md
Name: cpm_cnt_nest

Overview:
Parametrised nested-loop counter, successor to the single-level clear/enable counter in the CPM (compute-path manager) of the systolic array.
- Provides NUM_LVL chained counters, each DW wide, with per-level programmable terminal values latched at Start.
- Provides a run/done handshake and per-level wrap flags.
- Drives loop indices for SYA tile, channel and point iteration.

Parameters:
DW, 8, width of each level's counter
NUM_LVL, 3, number of nested levels; level 0 is innermost, placed at the LSB of packed buses

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  asynchronous active-high reset
Clear  input  1  synchronous clear: all counters to 0, FSM to IDLE
CfgMax  input  NUM_LVL*DW  per-level terminal value; level i uses bits [i*DW +: DW]; sampled only on accepted Start
Start  input  1  begin a run; accepted only in IDLE
Enable  input  1  advance one step; effective only in RUN
Cnt  output  NUM_LVL*DW  current per-level counts, packed like CfgMax
Wrap  output  NUM_LVL  combinational; Wrap[i]=1 when the current Enable step wraps level i
Busy  output  1  1 in RUN
Done  output  1  one-cycle pulse after the final step

Behaviour:
- Reset (Rst=1, asynchronous):
  - FSM=IDLE.
  - Cnt, latched max registers, Busy, Done all 0.
- Priority: Rst > Clear > Start > Enable.
- Clear: Cnt=0, FSM=IDLE, Done=0 next cycle. Latched max values are kept but unused.
- FSM states IDLE, RUN, DONE:
  - IDLE: Start=1 -> latch CfgMax, Cnt=0, go RUN next cycle. Enable ignored.
  - RUN:
    - carry0 = Enable.
    - carry(i+1) = carry(i) & (Cnt_i == Max_i).
    - Wrap[i] = carry(i) & (Cnt_i == Max_i).
    - Level i with carry(i)=1: Cnt_i <= Wrap[i] ? 0 : Cnt_i+1.
    - When Wrap[NUM_LVL-1]=1 (final step): all Cnt return to 0 and FSM -> DONE.
  - DONE: Done=1 for exactly this cycle, Busy=0, then -> IDLE. Start and Enable ignored in DONE.
- Outputs:
  - Busy = (state==RUN), registered.
  - Wrap is 0 outside RUN.
- Total steps per run = product over i of (Max_i+1).
  - Done is asserted in the cycle after the clock edge that accepts the final Enable (latency 1).
- Max_i=0: level i stays 0; its Wrap[i] equals carry(i), so the carry passes straight through.
- All Max=0: the first Enable in RUN completes the run.
- Enable low in RUN: counts hold; no timeout.
- Start while RUN/DONE: ignored; CfgMax changes mid-run have no effect.
- Rst mid-run: immediate return to reset values; no Done pulse.
- Arithmetic: unsigned. Increment never exceeds Max_i, so no DW overflow. Max_i = 2^DW-1 is legal and wraps to 0.

Optional Feature:
Macro CPM_CNT_NEST_LINCNT_EN.
- Defined:
  - Extra output LinCnt, width NUM_LVL*DW.
  - Cleared to 0 on Rst, Clear and accepted Start.
  - Increments by 1 on every effective Enable in RUN.
  - Holds its value (total steps) through DONE and IDLE until the next Start or Clear.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset/idle: assert Rst mid-cycle, then release; pulse Enable in IDLE -> Cnt=0, Busy=0, Done=0 throughout.
- Full nest run: DW=4, NUM_LVL=3, CfgMax levels {L2=2, L1=1, L0=3}, Start, then Enable held high.
  - 24 steps in total.
  - After step 4: Cnt L0=0, L1=1, L2=0; Wrap=001 on step 4.
  - After step 8: L1 wraps; Wrap=011 on step 8.
  - Step 24: Wrap=111; Done pulses one cycle later; Cnt all 0; Busy falls with Done.
  - LinCnt=24 when CPM_CNT_NEST_LINCNT_EN is defined.
- Stalls: same config with Enable toggled 1,0,0,1 pattern -> counts advance only on Enable=1 cycles; Done still follows exactly the 24th effective Enable.
- Degenerate max: CfgMax all 0, Start, single Enable -> Wrap=111 that cycle, Done next cycle. Levels {L1=0, L0=2}: Wrap[1] asserted with every Wrap[0].
- Ignored Start/config change: mid-run pulse Start with a different CfgMax -> no restart; sequence and step count unchanged.
- Clear mid-run: Clear at step 10 -> next cycle Cnt=0, IDLE, no Done; a new Start runs a full sequence normally.
